// File: rtl/bus_master_arbiter_if.sv
// Purpose: bundle of every handshake/serial signal between two bus masters,
//          the arbiter and the downstream address decoder.
// Modports:
//   slave  - arbiter view: takes m1_*/m2_* requests and data, drives grants and
//            returned data; drives d_* toward the decoder, takes d_* replies.
//   master - environment view (masters + decoder), directions reversed.
interface bus_master_arbiter_if;
  logic m1_breq, m1_bgrant, m1_mode, m1_wr_bus, m1_master_valid, m1_master_ready;
  logic m1_rd_bus, m1_ack, m1_slave_ready, m1_slave_valid;
  logic m2_breq, m2_bgrant, m2_mode, m2_wr_bus, m2_master_valid, m2_master_ready;
  logic m2_rd_bus, m2_ack, m2_slave_ready, m2_slave_valid;
  logic d_mode, d_wr_bus, d_master_valid, d_master_ready;
  logic d_rd_bus, d_ack, d_slave_ready, d_slave_valid;

  modport slave (
    input  m1_breq, m1_mode, m1_wr_bus, m1_master_valid, m1_master_ready,
    output m1_bgrant, m1_rd_bus, m1_ack, m1_slave_ready, m1_slave_valid,
    input  m2_breq, m2_mode, m2_wr_bus, m2_master_valid, m2_master_ready,
    output m2_bgrant, m2_rd_bus, m2_ack, m2_slave_ready, m2_slave_valid,
    output d_mode, d_wr_bus, d_master_valid, d_master_ready,
    input  d_rd_bus, d_ack, d_slave_ready, d_slave_valid
  );

  modport master (
    output m1_breq, m1_mode, m1_wr_bus, m1_master_valid, m1_master_ready,
    input  m1_bgrant, m1_rd_bus, m1_ack, m1_slave_ready, m1_slave_valid,
    output m2_breq, m2_mode, m2_wr_bus, m2_master_valid, m2_master_ready,
    input  m2_bgrant, m2_rd_bus, m2_ack, m2_slave_ready, m2_slave_valid,
    input  d_mode, d_wr_bus, d_master_valid, d_master_ready,
    output d_rd_bus, d_ack, d_slave_ready, d_slave_valid
  );
endinterface

// File: rtl/bus_master_arbiter.sv
// Purpose: shares the decoder's single serial master port between masters M1
//          and M2. Round-robin on simultaneous requests, idle-grant revocation
//          when the other master waits, one-cycle HANDOVER between owners.
// Ports:
//   clk   - system clock, rising edge
//   rstn  - asynchronous active-low reset
//   bus   - bus_master_arbiter_if.slave: m1_*/m2_* master side, d_* decoder side
module bus_master_arbiter #(
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  bus_master_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(IDLE_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_REVOKE = CNT_W'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT1   = 2'd1,
    ST_GRANT2   = 2'd2,
    ST_HANDOVER = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             last_m2_q, last_m2_d;  // 1: M2 held the last grant
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic own_breq, own_valid, other_breq, granted_m2;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      last_m2_q <= 1'b1;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_m2_q <= last_m2_d;
      cnt_q     <= cnt_d;
    end
  end

  // Signals of the current owner, selected by state
  always_comb begin
    granted_m2 = (state_q == ST_GRANT2);
    own_breq   = granted_m2 ? bus.m2_breq         : bus.m1_breq;
    own_valid  = granted_m2 ? bus.m2_master_valid : bus.m1_master_valid;
    other_breq = granted_m2 ? bus.m1_breq         : bus.m2_breq;
  end

  // Next-state, round-robin and idle counter
  always_comb begin
    state_d   = state_q;
    last_m2_d = last_m2_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.m1_breq && bus.m2_breq) state_d = last_m2_q ? ST_GRANT1 : ST_GRANT2;
        else if (bus.m1_breq)           state_d = ST_GRANT1;
        else if (bus.m2_breq)           state_d = ST_GRANT2;
      end
      ST_GRANT1, ST_GRANT2: begin
        // Release or revoke; both together still give a single HANDOVER
        if (!own_breq || (cnt_q == CNT_REVOKE && !own_valid && other_breq)) begin
          state_d   = ST_HANDOVER;
          last_m2_d = granted_m2;
          cnt_d     = '0;
        end else if (own_valid) begin
          cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HANDOVER: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.m1_bgrant = (state_q == ST_GRANT1);
  assign bus.m2_bgrant = (state_q == ST_GRANT2);

  // Zero-latency routing between the owner and the decoder; everything else 0
  always_comb begin
    bus.d_mode          = 1'b0;
    bus.d_wr_bus        = 1'b0;
    bus.d_master_valid  = 1'b0;
    bus.d_master_ready  = 1'b0;
    bus.m1_rd_bus       = 1'b0;
    bus.m1_ack          = 1'b0;
    bus.m1_slave_ready  = 1'b0;
    bus.m1_slave_valid  = 1'b0;
    bus.m2_rd_bus       = 1'b0;
    bus.m2_ack          = 1'b0;
    bus.m2_slave_ready  = 1'b0;
    bus.m2_slave_valid  = 1'b0;
    case (state_q)
      ST_GRANT1: begin
        bus.d_mode         = bus.m1_mode;
        bus.d_wr_bus       = bus.m1_wr_bus;
        bus.d_master_valid = bus.m1_master_valid;
        bus.d_master_ready = bus.m1_master_ready;
        bus.m1_rd_bus      = bus.d_rd_bus;
        bus.m1_ack         = bus.d_ack;
        bus.m1_slave_ready = bus.d_slave_ready;
        bus.m1_slave_valid = bus.d_slave_valid;
      end
      ST_GRANT2: begin
        bus.d_mode         = bus.m2_mode;
        bus.d_wr_bus       = bus.m2_wr_bus;
        bus.d_master_valid = bus.m2_master_valid;
        bus.d_master_ready = bus.m2_master_ready;
        bus.m2_rd_bus      = bus.d_rd_bus;
        bus.m2_ack         = bus.d_ack;
        bus.m2_slave_ready = bus.d_slave_ready;
        bus.m2_slave_valid = bus.d_slave_valid;
      end
      default: ;
    endcase
  end

endmodule
